// File: rtl/shield_read_stream.sv
// rtl/shield_read_stream.sv - word-granular read command to cache-line requests and 64-bit output stream
module shield_read_stream #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [31:0]      rd_req_addr,
    output logic             rd_req_val,
    input  logic             rd_req_rdy,
    input  logic [31:0]      rd_resp_addr,
    input  logic [511:0]     rd_resp_data,
    input  logic             rd_resp_val,
    output logic             rd_resp_rdy,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t           state;
    logic [25:0]      line_addr;
    logic [2:0]       word_idx;
    logic [LEN_W-1:0] words_left;
    logic [511:0]     line_buf;
    logic             unused_bits;

    assign unused_bits = ^{cmd_addr[2:0], rd_resp_addr[5:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            line_addr  <= '0;
            word_idx   <= '0;
            words_left <= '0;
            line_buf   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // a zero-length command is accepted but generates no traffic
                    if (cmd_val && cmd_len != '0) begin
                        line_addr  <= cmd_addr[31:6];
                        word_idx   <= cmd_addr[5:3];
                        words_left <= cmd_len;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (rd_req_rdy) state <= WAIT;
                end
                WAIT: begin
                    if (rd_resp_val) begin
                        line_buf <= rd_resp_data;
                        if (rd_resp_addr[31:6] != line_addr) err <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_rdy) begin
                        words_left <= words_left - 1'b1;
                        word_idx   <= word_idx + 3'd1;
                        if (words_left == LEN_W'(1)) begin
                            state <= IDLE;
                        end else if (word_idx == 3'd7) begin
                            line_addr <= line_addr + 26'd1;
                            state     <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // every handshake output is a pure decode of the state register
    assign cmd_rdy     = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rd_req_val  = (state == REQ);
    assign rd_resp_rdy = (state == WAIT);
    assign out_val     = (state == DRAIN);
    assign out_last    = out_val && (words_left == LEN_W'(1));
    assign out_data    = out_val ? line_buf[{word_idx, 6'b0} +: 64] : 64'h0;
    assign rd_req_addr = rd_req_val ? {line_addr, 6'b0} : 32'h0;

endmodule

// File: tb/tb_shield_read_stream.sv
// tb/tb_shield_read_stream.sv - randomized bench with a queue-based reference model for shield_read_stream
module tb_shield_read_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cmd_addr;
    logic [15:0]  cmd_len;
    logic         cmd_val;
    logic         cmd_rdy;
    logic [63:0]  out_data;
    logic         out_last;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  rd_req_addr;
    logic         rd_req_val;
    logic         rd_req_rdy;
    logic [31:0]  rd_resp_addr;
    logic [511:0] rd_resp_data;
    logic         rd_resp_val;
    logic         rd_resp_rdy;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    shield_read_stream #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .out_data(out_data), .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy),
        .rd_req_addr(rd_req_addr), .rd_req_val(rd_req_val), .rd_req_rdy(rd_req_rdy),
        .rd_resp_addr(rd_resp_addr), .rd_resp_data(rd_resp_data), .rd_resp_val(rd_resp_val),
        .rd_resp_rdy(rd_resp_rdy), .busy(busy), .err(err)
    );

    typedef struct {
        logic [63:0] data;
        bit          last;
        bit          line_end;
    } beat_t;

    int          vectors = 0;
    int          miscompares = 0;
    beat_t       exp_beat[$];
    logic [31:0] exp_req[$];
    logic [63:0] obs_data[$];
    bit          obs_last[$];
    logic [31:0] obs_req[$];

    logic [31:0] pend_addr;
    logic [15:0] pend_len;
    bit          pend_valid = 0;
    int          rdy_mode = 0;
    bit          alt = 0;
    bit          corrupt = 0;
    bit          data_mode = 0;
    int          rst_at_beat = 0;
    int          cmd_beats = 0;

    bit          exp_req_next = 0, exp_out_next = 0, exp_idle_next = 0, exp_reset_vals = 0;
    bit          err_model = 0;
    bit          resp_pend = 0;
    logic [31:0] resp_line;
    int          resp_lat = 0;
    bit          prev_req_stall = 0, prev_out_stall = 0;
    logic [31:0] prev_req_addr;
    logic [63:0] prev_out_data;
    bit          prev_out_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // word at a byte address: mode 0 is the plain line-address memory, mode 1 makes every word distinct
    function automatic logic [63:0] mem_word(input logic [31:0] ba);
        if (data_mode) return {~ba, ba};
        return {32'h0, ba & 32'hffff_ffc0};
    endfunction

    task automatic expect_cmd(input logic [31:0] a, input logic [15:0] l);
        logic [31:0] ba;
        beat_t       b;
        if (l == 0) return;
        exp_req.push_back(a & 32'hffff_ffc0);
        for (int k = 0; k < int'(l); k++) begin
            ba         = (a & 32'hffff_fff8) + 32'(8 * k);
            b.data     = mem_word(ba);
            b.last     = (k == int'(l) - 1);
            b.line_end = (ba[5:3] == 3'd7);
            exp_beat.push_back(b);
            if (b.line_end && !b.last) exp_req.push_back(ba + 32'd8);
        end
    endtask

    task automatic step();
        bit    cmd_hs, req_hs, resp_hs, out_hs, do_rst;
        beat_t b;
        @(negedge clk);
        if (exp_reset_vals) begin
            chk("reset_ctrl", {57'h0, cmd_rdy, out_val, out_last, rd_req_val, rd_resp_rdy, busy, err},
                64'b100_0000);
            chk("reset_out_data", out_data, 64'h0);
            chk("reset_req_addr", {32'h0, rd_req_addr}, 64'h0);
        end
        if (exp_req_next)  chk("req_follows", {63'h0, rd_req_val}, 64'h1);
        if (exp_out_next)  chk("beat_follows", {63'h0, out_val}, 64'h1);
        if (exp_idle_next) chk("idle_after_last", {62'h0, cmd_rdy, busy}, 64'b10);
        chk("busy_vs_cmd_rdy", {63'h0, busy}, {63'h0, !cmd_rdy});
        chk("err", {63'h0, err}, {63'h0, err_model});
        if (rd_req_val && exp_req.size() == 0) fail("unexpected_req");
        if (rd_req_val && prev_req_stall) chk("req_addr_stable", {32'h0, rd_req_addr}, {32'h0, prev_req_addr});
        if (out_val) begin
            if (exp_beat.size() == 0) fail("unexpected_beat");
            else begin
                chk("out_data", out_data, exp_beat[0].data);
                chk("out_last", {63'h0, out_last}, {63'h0, exp_beat[0].last});
            end
            if (prev_out_stall) begin
                chk("out_data_stable", out_data, prev_out_data);
                chk("out_last_stable", {63'h0, out_last}, {63'h0, prev_out_last});
            end
        end

        do_rst = (rst_at_beat > 0 && cmd_beats == rst_at_beat - 1 && out_val);
        if (do_rst) rst_at_beat = 0;
        reset    = do_rst;
        cmd_val  = pend_valid;
        cmd_addr = pend_addr;
        cmd_len  = pend_len;
        if (!pend_valid && !cmd_rdy) begin
            cmd_val  = ($urandom_range(0, 1) == 1);
            cmd_addr = $urandom;
            cmd_len  = 16'($urandom_range(1, 9));
        end
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = alt;
            default: out_rdy = ($urandom_range(0, 2) != 0);
        endcase
        alt          = !alt;
        rd_req_rdy   = ($urandom_range(0, 2) != 0);
        rd_resp_val  = resp_pend && (resp_lat == 0);
        rd_resp_addr = corrupt ? resp_line + 32'h40 : resp_line;
        for (int i = 0; i < 8; i++) rd_resp_data[i*64 +: 64] = mem_word(resp_line + 32'(8 * i));

        prev_req_stall = rd_req_val && !rd_req_rdy;
        prev_req_addr  = rd_req_addr;
        prev_out_stall = out_val && !out_rdy;
        prev_out_data  = out_data;
        prev_out_last  = out_last;
        exp_req_next   = 0;
        exp_out_next   = 0;
        exp_idle_next  = 0;
        exp_reset_vals = 0;

        if (do_rst) begin
            exp_beat.delete();
            exp_req.delete();
            resp_pend      = 0;
            err_model      = 0;
            pend_valid     = 0;
            prev_req_stall = 0;
            prev_out_stall = 0;
            exp_reset_vals = 1;
            return;
        end

        cmd_hs  = cmd_val && cmd_rdy;
        req_hs  = rd_req_val && rd_req_rdy;
        resp_hs = rd_resp_val && rd_resp_rdy;
        out_hs  = out_val && out_rdy;

        if (cmd_hs) begin
            pend_valid = 0;
            cmd_beats  = 0;
            expect_cmd(cmd_addr, cmd_len);
            if (cmd_len != 0) exp_req_next = 1;
            else              exp_idle_next = 1;
        end
        if (resp_hs) begin
            resp_pend    = 0;
            exp_out_next = 1;
            if (corrupt) err_model = 1;
        end else if (resp_pend && resp_lat > 0) begin
            resp_lat--;
        end
        if (req_hs) begin
            if (exp_req.size() > 0) chk("req_addr", {32'h0, rd_req_addr}, {32'h0, exp_req.pop_front()});
            obs_req.push_back(rd_req_addr);
            resp_pend = 1;
            resp_line = rd_req_addr;
            resp_lat  = $urandom_range(0, 3);
        end
        if (out_hs && exp_beat.size() > 0) begin
            b = exp_beat.pop_front();
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
            cmd_beats++;
            if (b.last)          exp_idle_next = 1;
            else if (b.line_end) exp_req_next = 1;
            else                 exp_out_next = 1;
        end
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] l, input int mode, input int rst_beat);
        pend_addr   = a;
        pend_len    = l;
        pend_valid  = 1;
        rdy_mode    = mode;
        rst_at_beat = rst_beat;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!pend_valid && exp_beat.size() == 0) begin
                step();
                return;
            end
        end
        fail("cmd_timeout");
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        obs_req.delete();
    endtask

    initial begin
        reset = 1; cmd_val = 0; cmd_addr = 0; cmd_len = 0; out_rdy = 0;
        rd_req_rdy = 0; rd_resp_val = 0; rd_resp_addr = 0; rd_resp_data = '0;
        repeat (2) @(negedge clk);
        exp_reset_vals = 1;

        clear_obs();
        run_cmd(32'h0, 16'd8, 0, 0);
        chk("t1_nreq", obs_req.size(), 1);
        chk("t1_nbeats", obs_data.size(), 8);
        if (obs_req.size() == 1) chk("t1_req0", {32'h0, obs_req[0]}, 64'h0);
        if (obs_data.size() == 8) begin
            chk("t1_beat7_data", obs_data[7], 64'h0);
            chk("t1_last_flags", {56'h0, obs_last[7], obs_last[6], obs_last[5], obs_last[4],
                obs_last[3], obs_last[2], obs_last[1], obs_last[0]}, 64'h80);
        end

        clear_obs();
        run_cmd(32'h38, 16'd3, 2, 0);
        chk("t2_nreq", obs_req.size(), 2);
        if (obs_req.size() == 2) chk("t2_req1", {32'h0, obs_req[1]}, 64'h40);
        if (obs_data.size() == 3) begin
            chk("t2_beat0", obs_data[0], 64'h0);
            chk("t2_beat1", obs_data[1], 64'h40);
            chk("t2_beat2", obs_data[2], 64'h40);
            chk("t2_last", {62'h0, obs_last[1], obs_last[2]}, 64'b01);
        end else fail("t2_nbeats");

        clear_obs();
        run_cmd(32'hffff_ffc0, 16'd10, 2, 0);
        if (obs_req.size() == 2) begin
            chk("t3_req0", {32'h0, obs_req[0]}, 64'hffff_ffc0);
            chk("t3_req1", {32'h0, obs_req[1]}, 64'h0);
        end else fail("t3_nreq");
        if (obs_data.size() == 10) begin
            chk("t3_beat7", obs_data[7], 64'hffff_ffc0);
            chk("t3_beat8", obs_data[8], 64'h0);
        end else fail("t3_nbeats");

        clear_obs();
        run_cmd(32'h100, 16'd0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_quiet", {61'h0, busy, out_val, rd_req_val}, 64'h0);
        end
        chk("t4_nreq", obs_req.size(), 0);

        clear_obs();
        run_cmd(32'h0001_0000, 16'd16, 1, 0);
        chk("t5_nbeats", obs_data.size(), 16);
        if (obs_req.size() == 2) chk("t5_req1", {32'h0, obs_req[1]}, 64'h1_0040);
        else fail("t5_nreq");
        chk("t5_err_clear", {63'h0, err}, 64'h0);

        corrupt = 1;
        run_cmd(32'h0001_0000, 16'd16, 1, 0);
        corrupt = 0;
        run_cmd(32'h0000_0200, 16'd5, 2, 0);
        chk("t5_err_sticky", {63'h0, err}, 64'h1);

        clear_obs();
        run_cmd(32'h0, 16'd8, 0, 4);
        chk("t6_beats_before_reset", obs_data.size(), 3);
        chk("t6_err_cleared", {63'h0, err}, 64'h0);
        clear_obs();
        run_cmd(32'h0, 16'd1, 0, 0);
        if (obs_data.size() == 1) begin
            chk("t6_beat", obs_data[0], 64'h0);
            chk("t6_last", {63'h0, obs_last[0]}, 64'h1);
        end else fail("t6_nbeats");

        data_mode = 1;
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = $urandom;
            if (t % 4 == 0) a = 32'hffff_ff00 | (a & 32'hff);
            corrupt = (t == 30);
            run_cmd(a, 16'($urandom_range(0, 20)), $urandom_range(0, 2), 0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
